// File: rtl/jtdd_prog_sdram_pkg.sv
// Shared definitions for the ROM-download SDRAM writer: command encodings,
// controller states, default timings and the latched request layout.
package jtdd_sdram_pkg;

   // {cs_n, ras_n, cas_n, we_n}
   typedef enum logic [3:0] {
      CMD_LOAD_MODE = 4'b0000,
      CMD_REFRESH   = 4'b0001,
      CMD_PRECHARGE = 4'b0010,
      CMD_ACTIVE    = 4'b0011,
      CMD_WRITE     = 4'b0100,
      CMD_NOP       = 4'b0111,
      CMD_INHIBIT   = 4'b1111
   } sdram_cmd_e;

   typedef enum logic [3:0] {
      ST_INIT_WAIT,
      ST_INIT_PRE,
      ST_INIT_REF1,
      ST_INIT_REF2,
      ST_INIT_MODE,
      ST_IDLE,
      ST_REF,
      ST_ACT,
      ST_WR
   } state_e;

   localparam int unsigned T_INIT_DEF = 9600;
   localparam int unsigned T_RCD_DEF  = 2;
   localparam int unsigned T_WRP_DEF  = 4;
   localparam int unsigned T_RFC_DEF  = 7;
   localparam int unsigned T_REFI_DEF = 370;
   localparam logic [12:0] MODE_DEF   = 13'h020;

   localparam int CNT_W = 16;

   typedef struct packed {
      logic [1:0] ba;
      logic [8:0] col;
      logic [7:0] data;
      logic [1:0] mask;
   } req_t;

   // Column address with A10 set so every write closes its own row.
   function automatic logic [12:0] col_addr(input logic [8:0] col);
      return {2'b00, 1'b1, 1'b0, col};
   endfunction

   function automatic logic [12:0] row_addr(input logic [10:0] row);
      return {2'b00, row};
   endfunction

endpackage

// File: rtl/jtdd_prog_sdram_if.sv
// Download-side request/ack signals plus the SDRAM pin bundle they drive.
interface jtdd_prog_sdram_if;
   logic        downloading;
   logic [21:0] prog_addr;
   logic [7:0]  prog_data;
   logic [1:0]  prog_mask;
   logic        prog_we;
   logic        sdram_ack;
   logic        init_done;
   logic        sdram_cke;
   logic [3:0]  sdram_cmd;
   logic [1:0]  sdram_ba;
   logic [12:0] sdram_a;
   logic [1:0]  sdram_dqm;
   logic [15:0] sdram_dq_out;
   logic        sdram_dq_oe;

   modport master (
      output downloading, prog_addr, prog_data, prog_mask, prog_we,
      input  sdram_ack, init_done, sdram_cke, sdram_cmd, sdram_ba,
             sdram_a, sdram_dqm, sdram_dq_out, sdram_dq_oe
   );

   modport slave (
      input  downloading, prog_addr, prog_data, prog_mask, prog_we,
      output sdram_ack, init_done, sdram_cke, sdram_cmd, sdram_ba,
             sdram_a, sdram_dqm, sdram_dq_out, sdram_dq_oe
   );
endinterface

// File: rtl/jtdd_sdram_refcnt.sv
// Auto-refresh interval timer: raises a sticky pending flag every T_REFI
// cycles while enabled; the controller clears it when it issues REFRESH.
module jtdd_sdram_refcnt
   import jtdd_sdram_pkg::*;
#(
   parameter int unsigned T_REFI = T_REFI_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_clr,
   output logic o_pend
);

   localparam int unsigned W = $clog2(T_REFI + 1);
   localparam logic [W-1:0] C_RELOAD = W'(T_REFI - 1);

   logic [W-1:0] r_cnt;
   logic         r_pend;
   logic         w_tc;

   assign w_tc   = (r_cnt == '0);
   assign o_pend = r_pend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_pend <= 1'b0;
      end else begin
         if (!i_en || w_tc)
            r_cnt <= C_RELOAD;
         else
            r_cnt <= r_cnt - W'(1);

         // A new interval expiring wins over a same-cycle clear.
         if (i_en && w_tc)
            r_pend <= 1'b1;
         else if (i_clr)
            r_pend <= 1'b0;
      end
   end

endmodule

// File: rtl/jtdd_prog_sdram.sv
// Download-time SDRAM writer: power-up init, then one ACTIVE/WRITE-with-
// auto-precharge per prog_we request, interleaved with periodic refresh.
//
// state        | meaning
// ST_INIT_WAIT | cke high, NOPs for T_INIT cycles, then PRECHARGE ALL
// ST_INIT_PRE  | NOPs after precharge, then first REFRESH
// ST_INIT_REF1 | T_RFC NOPs, then second REFRESH
// ST_INIT_REF2 | T_RFC NOPs, then LOAD MODE
// ST_INIT_MODE | two NOPs, then init_done and IDLE
// ST_IDLE      | refresh if pending, else accept a request, else NOP
// ST_REF       | T_RFC NOPs after a run-time REFRESH
// ST_ACT       | ACTIVE issued, waiting T_RCD for the WRITE
// ST_WR        | WRITE issued, waiting tWR+tRP, ack on the last cycle
module jtdd_prog_sdram
   import jtdd_sdram_pkg::*;
#(
   parameter int unsigned T_INIT = T_INIT_DEF,
   parameter int unsigned T_RCD  = T_RCD_DEF,
   parameter int unsigned T_WRP  = T_WRP_DEF,
   parameter int unsigned T_RFC  = T_RFC_DEF,
   parameter int unsigned T_REFI = T_REFI_DEF,
   parameter logic [12:0] MODE   = MODE_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   jtdd_prog_sdram_if.slave  bus
);

   localparam logic [CNT_W-1:0] C_INIT     = CNT_W'(T_INIT - 1);
   localparam logic [CNT_W-1:0] C_TWO      = CNT_W'(2);
   localparam logic [CNT_W-1:0] C_RFC      = CNT_W'(T_RFC);
   localparam logic [CNT_W-1:0] C_RFC_IDLE = CNT_W'(T_RFC - 1);
   localparam logic [CNT_W-1:0] C_RCD      = CNT_W'(T_RCD - 1);
   localparam logic [CNT_W-1:0] C_WRP      = CNT_W'(T_WRP - 1);

   state_e           r_state,     w_state_nx;
   logic [CNT_W-1:0] r_cnt,       w_cnt_nx;
   sdram_cmd_e       r_cmd,       w_cmd_nx;
   logic             r_cke;
   logic [1:0]       r_ba,        w_ba_nx;
   logic [12:0]      r_a,         w_a_nx;
   logic [1:0]       r_dqm,       w_dqm_nx;
   logic [15:0]      r_dq,        w_dq_nx;
   logic             r_oe,        w_oe_nx;
   logic             r_ack,       w_ack_nx;
   logic             r_init_done, w_done_nx;
   req_t             r_req,       w_req_nx;

   logic             w_tc;
   logic             w_ref_pend;
   logic             w_ref_clr;
   logic             w_accept;

   jtdd_sdram_refcnt #(
      .T_REFI (T_REFI)
   ) u_refcnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (r_init_done),
      .i_clr  (w_ref_clr),
      .o_pend (w_ref_pend)
   );

   assign w_tc = (r_cnt == '0);
   // The completed request is still on prog_we while ack is high.
   assign w_accept = bus.prog_we && bus.downloading && !r_ack;

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_cmd_nx   = CMD_NOP;
      w_ba_nx    = r_ba;
      w_a_nx     = r_a;
      w_dqm_nx   = 2'b11;
      w_dq_nx    = r_dq;
      w_oe_nx    = 1'b0;
      w_ack_nx   = 1'b0;
      w_done_nx  = r_init_done;
      w_req_nx   = r_req;
      w_ref_clr  = 1'b0;

      unique case (r_state)
         ST_INIT_WAIT: begin
            // cke still low means this is the first edge out of reset.
            if (!r_cke) begin
               w_cnt_nx = C_INIT;
            end else if (w_tc) begin
               w_cmd_nx   = CMD_PRECHARGE;
               w_a_nx     = 13'h0400;
               w_cnt_nx   = C_TWO;
               w_state_nx = ST_INIT_PRE;
            end else begin
               w_cnt_nx = r_cnt - CNT_W'(1);
            end
         end

         ST_INIT_PRE: begin
            if (w_tc) begin
               w_cmd_nx   = CMD_REFRESH;
               w_cnt_nx   = C_RFC;
               w_state_nx = ST_INIT_REF1;
            end else begin
               w_cnt_nx = r_cnt - CNT_W'(1);
            end
         end

         ST_INIT_REF1: begin
            if (w_tc) begin
               w_cmd_nx   = CMD_REFRESH;
               w_cnt_nx   = C_RFC;
               w_state_nx = ST_INIT_REF2;
            end else begin
               w_cnt_nx = r_cnt - CNT_W'(1);
            end
         end

         ST_INIT_REF2: begin
            if (w_tc) begin
               w_cmd_nx   = CMD_LOAD_MODE;
               w_ba_nx    = 2'b00;
               w_a_nx     = MODE;
               w_cnt_nx   = C_TWO;
               w_state_nx = ST_INIT_MODE;
            end else begin
               w_cnt_nx = r_cnt - CNT_W'(1);
            end
         end

         ST_INIT_MODE: begin
            if (w_tc) begin
               w_done_nx  = 1'b1;
               w_state_nx = ST_IDLE;
            end else begin
               w_cnt_nx = r_cnt - CNT_W'(1);
            end
         end

         ST_IDLE: begin
            if (w_ref_pend) begin
               w_cmd_nx   = CMD_REFRESH;
               w_ref_clr  = 1'b1;
               w_cnt_nx   = C_RFC_IDLE;
               w_state_nx = ST_REF;
            end else if (w_accept) begin
               w_req_nx.ba   = bus.prog_addr[21:20];
               w_req_nx.col  = bus.prog_addr[8:0];
               w_req_nx.data = bus.prog_data;
               w_req_nx.mask = bus.prog_mask;
               w_cmd_nx      = CMD_ACTIVE;
               w_ba_nx       = bus.prog_addr[21:20];
               w_a_nx        = row_addr(bus.prog_addr[19:9]);
               w_cnt_nx      = C_RCD;
               w_state_nx    = ST_ACT;
            end
         end

         ST_REF: begin
            if (w_tc)
               w_state_nx = ST_IDLE;
            else
               w_cnt_nx = r_cnt - CNT_W'(1);
         end

         ST_ACT: begin
            if (w_tc) begin
               w_cmd_nx   = CMD_WRITE;
               w_ba_nx    = r_req.ba;
               w_a_nx     = col_addr(r_req.col);
               w_oe_nx    = 1'b1;
               w_dqm_nx   = r_req.mask;
               w_dq_nx    = {r_req.data, r_req.data};
               w_cnt_nx   = C_WRP;
               w_state_nx = ST_WR;
            end else begin
               w_cnt_nx = r_cnt - CNT_W'(1);
            end
         end

         ST_WR: begin
            if (w_tc) begin
               w_ack_nx   = 1'b1;
               w_state_nx = ST_IDLE;
            end else begin
               w_cnt_nx = r_cnt - CNT_W'(1);
            end
         end

         default: begin
            w_state_nx = ST_INIT_WAIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_INIT_WAIT;
         r_cnt       <= '0;
         r_cmd       <= CMD_INHIBIT;
         r_cke       <= 1'b0;
         r_ba        <= 2'b00;
         r_a         <= 13'h0000;
         r_dqm       <= 2'b11;
         r_dq        <= 16'h0000;
         r_oe        <= 1'b0;
         r_ack       <= 1'b0;
         r_init_done <= 1'b0;
         r_req       <= '0;
      end else begin
         r_state     <= w_state_nx;
         r_cnt       <= w_cnt_nx;
         r_cmd       <= w_cmd_nx;
         r_cke       <= 1'b1;
         r_ba        <= w_ba_nx;
         r_a         <= w_a_nx;
         r_dqm       <= w_dqm_nx;
         r_dq        <= w_dq_nx;
         r_oe        <= w_oe_nx;
         r_ack       <= w_ack_nx;
         r_init_done <= w_done_nx;
         r_req       <= w_req_nx;
      end
   end

   assign bus.sdram_ack    = r_ack;
   assign bus.init_done    = r_init_done;
   assign bus.sdram_cke    = r_cke;
   assign bus.sdram_cmd    = r_cmd;
   assign bus.sdram_ba     = r_ba;
   assign bus.sdram_a      = r_a;
   assign bus.sdram_dqm    = r_dqm;
   assign bus.sdram_dq_out = r_dq;
   assign bus.sdram_dq_oe  = r_oe;

endmodule

// File: tb/tb_jtdd_prog_sdram.sv
// Directed bench for the download SDRAM writer; cycle k is the period after
// the k-th rising edge following reset release, sampled on the falling edge.
module tb_jtdd_prog_sdram;
   import jtdd_sdram_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc;
   int   n_vec = 0;
   int   n_err = 0;
   int   n_wr = 0;
   int   n_ack = 0;

   always #5 clk = ~clk;

   jtdd_prog_sdram_if bus();

   jtdd_prog_sdram #(
      .T_INIT (16),
      .T_RCD  (2),
      .T_WRP  (4),
      .T_RFC  (7),
      .T_REFI (100),
      .MODE   (13'h020)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.sdram_cmd == CMD_WRITE) n_wr <= n_wr + 1;
         if (bus.sdram_ack)              n_ack <= n_ack + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic at_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic req(input logic [21:0] addr, input logic [7:0] data, input logic [1:0] mask);
      bus.prog_addr = addr;
      bus.prog_data = data;
      bus.prog_mask = mask;
      bus.prog_we   = 1'b1;
   endtask

   task automatic chk_init(input string pfx);
      at_cyc(1);  chk({pfx, "cke_c1"}, bus.sdram_cke, 1'b1);
                  chk({pfx, "nop_c1"}, bus.sdram_cmd, CMD_NOP);
      at_cyc(16); chk({pfx, "nop_c16"}, bus.sdram_cmd, CMD_NOP);
      at_cyc(17); chk({pfx, "pre_c17"}, bus.sdram_cmd, CMD_PRECHARGE);
                  chk({pfx, "pre_a10"}, bus.sdram_a[10], 1'b1);
      at_cyc(20); chk({pfx, "ref1_c20"}, bus.sdram_cmd, CMD_REFRESH);
      at_cyc(21); chk({pfx, "nop_c21"}, bus.sdram_cmd, CMD_NOP);
      at_cyc(28); chk({pfx, "ref2_c28"}, bus.sdram_cmd, CMD_REFRESH);
      at_cyc(36); chk({pfx, "lmr_c36"}, bus.sdram_cmd, CMD_LOAD_MODE);
                  chk({pfx, "lmr_a"}, bus.sdram_a, 13'h020);
                  chk({pfx, "lmr_ba"}, bus.sdram_ba, 2'b00);
      at_cyc(38); chk({pfx, "done_c38"}, bus.init_done, 1'b0);
      at_cyc(39); chk({pfx, "done_c39"}, bus.init_done, 1'b1);
                  chk({pfx, "idle_c39"}, bus.sdram_cmd, CMD_NOP);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1);
   end

   initial begin
      bus.downloading = 1'b1;
      bus.prog_addr   = '0;
      bus.prog_data   = '0;
      bus.prog_mask   = '0;
      bus.prog_we     = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_cmd", bus.sdram_cmd, CMD_INHIBIT);
      chk("rst_cke", bus.sdram_cke, 1'b0);
      chk("rst_dqm", bus.sdram_dqm, 2'b11);
      chk("rst_oe", bus.sdram_dq_oe, 1'b0);
      chk("rst_ack", bus.sdram_ack, 1'b0);
      chk("rst_done", bus.init_done, 1'b0);
      rst_n = 1'b1;

      // Request raised during init is held until the controller is ready.
      at_cyc(10); req(22'h12345, 8'hA5, 2'b10);
      chk_init("i1_");

      at_cyc(40); chk("w1_act", bus.sdram_cmd, CMD_ACTIVE);
                  chk("w1_act_ba", bus.sdram_ba, 2'd0);
                  chk("w1_act_a", bus.sdram_a, 13'h091);
      at_cyc(41); chk("w1_nop", bus.sdram_cmd, CMD_NOP);
      at_cyc(42); chk("w1_wr", bus.sdram_cmd, CMD_WRITE);
                  chk("w1_wr_a", bus.sdram_a, 13'h545);
                  chk("w1_wr_dq", bus.sdram_dq_out, 16'hA5A5);
                  chk("w1_wr_dqm", bus.sdram_dqm, 2'b10);
                  chk("w1_wr_oe", bus.sdram_dq_oe, 1'b1);
      at_cyc(43); chk("w1_oe_off", bus.sdram_dq_oe, 1'b0);
                  chk("w1_dqm_off", bus.sdram_dqm, 2'b11);
      at_cyc(45); chk("w1_ack_early", bus.sdram_ack, 1'b0);
      at_cyc(46); chk("w1_ack", bus.sdram_ack, 1'b1);
      at_cyc(47); chk("w1_ack_1cyc", bus.sdram_ack, 1'b0);
                  bus.prog_we = 1'b0;
      at_cyc(58); chk("w1_nwr", n_wr, 1);
                  chk("w1_nack", n_ack, 1);

      // Back-to-back: new request presented in the ack cycle.
      at_cyc(60); req(22'h3C0201, 8'h5A, 2'b00);
      at_cyc(61); chk("w2_act", bus.sdram_cmd, CMD_ACTIVE);
                  chk("w2_act_ba", bus.sdram_ba, 2'd3);
                  chk("w2_act_a", bus.sdram_a, 13'h0601);
      at_cyc(63); chk("w2_wr_a", bus.sdram_a, 13'h401);
                  chk("w2_wr_dq", bus.sdram_dq_out, 16'h5A5A);
      at_cyc(67); chk("w2_ack", bus.sdram_ack, 1'b1);
                  req(22'h2001FF, 8'h3C, 2'b01);
      at_cyc(68); chk("w3_blocked", bus.sdram_cmd, CMD_NOP);
      at_cyc(69); chk("w3_act", bus.sdram_cmd, CMD_ACTIVE);
                  chk("w3_act_ba", bus.sdram_ba, 2'd2);
                  chk("w3_act_a", bus.sdram_a, 13'h000);
      at_cyc(70); bus.prog_data = 8'hFF;
      at_cyc(71); chk("w3_wr", bus.sdram_cmd, CMD_WRITE);
                  chk("w3_wr_a", bus.sdram_a, 13'h5FF);
                  chk("w3_wr_dq", bus.sdram_dq_out, 16'h3C3C);
                  chk("w3_wr_dqm", bus.sdram_dqm, 2'b01);
      at_cyc(75); chk("w3_ack", bus.sdram_ack, 1'b1);
                  bus.prog_we = 1'b0;

      // Fully masked write; downloading drops mid-sequence.
      at_cyc(85); req(22'h000000, 8'h11, 2'b11);
      at_cyc(86); chk("w4_act", bus.sdram_cmd, CMD_ACTIVE);
      at_cyc(87); bus.downloading = 1'b0;
      at_cyc(88); chk("w4_wr_oe", bus.sdram_dq_oe, 1'b1);
                  chk("w4_wr_dqm", bus.sdram_dqm, 2'b11);
                  chk("w4_wr_dq", bus.sdram_dq_out, 16'h1111);
      at_cyc(92); chk("w4_ack", bus.sdram_ack, 1'b1);
      at_cyc(100); chk("w4_nwr", n_wr, 4);
                   chk("w4_nack", n_ack, 4);
                   bus.prog_we = 1'b0;
                   bus.downloading = 1'b1;

      // Refresh becomes pending in cycle 139; request arrives the same cycle.
      at_cyc(139); chk("r1_idle", bus.sdram_cmd, CMD_NOP);
                   req(22'h155555, 8'hC3, 2'b00);
      at_cyc(140); chk("r1_ref", bus.sdram_cmd, CMD_REFRESH);
      at_cyc(147); chk("r1_rfc_nop", bus.sdram_cmd, CMD_NOP);
      at_cyc(148); chk("w5_act", bus.sdram_cmd, CMD_ACTIVE);
                   chk("w5_act_ba", bus.sdram_ba, 2'd1);
                   chk("w5_act_a", bus.sdram_a, 13'h2AA);
      at_cyc(154); chk("w5_ack", bus.sdram_ack, 1'b1);
                   bus.prog_we = 1'b0;

      // Refresh falls due during the write and waits for IDLE.
      at_cyc(236); req(22'h000200, 8'h77, 2'b00);
      at_cyc(239); chk("w6_wr", bus.sdram_cmd, CMD_WRITE);
      at_cyc(240); chk("w6_no_ref", bus.sdram_cmd, CMD_NOP);
      at_cyc(243); chk("w6_ack", bus.sdram_ack, 1'b1);
                   bus.prog_we = 1'b0;
      at_cyc(244); chk("r2_ref", bus.sdram_cmd, CMD_REFRESH);

      // Reset in the WRITE cycle abandons the access.
      at_cyc(260); req(22'h12345, 8'h99, 2'b00);
      at_cyc(263); chk("w7_wr", bus.sdram_cmd, CMD_WRITE);
                   chk("w7_nack_pre", n_ack, 6);
      rst_n = 1'b0;
      #1;
      chk("rst2_cmd", bus.sdram_cmd, CMD_INHIBIT);
      chk("rst2_cke", bus.sdram_cke, 1'b0);
      chk("rst2_oe", bus.sdram_dq_oe, 1'b0);
      chk("rst2_done", bus.init_done, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk_init("i2_");
      at_cyc(40); chk("w8_act", bus.sdram_cmd, CMD_ACTIVE);
                  chk("w8_act_a", bus.sdram_a, 13'h091);
                  chk("w8_nack", n_ack, 6);
      at_cyc(46); chk("w8_ack", bus.sdram_ack, 1'b1);
                  bus.prog_we = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
